// File: rtl/pulse_tracer.sv
// pulse_tracer: glitch filter and rising-edge pulse generator for a single-bit level input.
//
// A qualified event is FILTER_LEN consecutive high samples of noisy_in. The block emits
// one registered, one-clock pulse per qualified high run. Shorter bursts produce nothing.
// A single low sample clears the run completely.
//
// Ports:
//   clk       - system clock; all state updates on the rising edge
//   rst_n     - asynchronous, active-low reset
//   noisy_in  - raw level input, already synchronous to clk
//   pulse_out - one-cycle, active-high pulse marking a qualified event (straight from a flop)
module pulse_tracer #(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic noisy_in,
    output logic pulse_out
);

    localparam int unsigned CntW = $clog2(FILTER_LEN + 1);

    // Full-width constants, so the saturation compare never truncates and cnt never wraps.
    localparam logic [CntW-1:0] MaxCnt  = CntW'(FILTER_LEN);
    localparam logic [CntW-1:0] LastCnt = CntW'(FILTER_LEN - 1);

    if (FILTER_LEN < 1 || FILTER_LEN > 255) begin : gen_bad_filter_len
        $error("pulse_tracer: FILTER_LEN must be in 1..255");
    end

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pulse_q, pulse_d;

    always_comb begin
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (!noisy_in) begin
            cnt_d = '0;
        end else if (cnt_q < MaxCnt) begin
            cnt_d   = cnt_q + 1'b1;
            // The edge that samples the FILTER_LEN-th high fires the pulse.
            pulse_d = (cnt_q == LastCnt);
        end
        // A saturated count holds, which keeps long runs to a single pulse.
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_out = pulse_q;

endmodule

// File: tb/tb_pulse_tracer.sv
// tb_pulse_tracer: directed and randomized bench for pulse_tracer with FILTER_LEN=3.
//
// The reference model counts the length of the current high run as an unbounded integer.
// After each sampling edge a pulse is expected exactly when that length equals FILTER_LEN,
// which gives one pulse per run, on the FILTER_LEN-th high.
module tb_pulse_tracer;

    localparam int unsigned FilterLen = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic noisy_in;
    logic pulse_out;

    int checks = 0;
    int errors = 0;
    int run_len = 0;
    int pulses_seen = 0;
    int last_pulse_cyc = -1;
    int cyc = 0;
    int gap = 0;

    pulse_tracer #(
        .FILTER_LEN(FilterLen)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .noisy_in (noisy_in),
        .pulse_out(pulse_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic expected);
        checks++;
        assert (pulse_out === expected)
        else begin
            errors++;
            $error("FAIL %s: pulse_out=%b expected %b (cycle %0d)", tag, pulse_out, expected, cyc);
        end
    endtask

    task automatic check_int(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one sample, let the edge take it, update the model, then check 1 ns later.
    task automatic step(input logic v, input string tag);
        logic expected;
        noisy_in = v;
        @(posedge clk);
        cyc++;
        if (v) run_len++;
        else run_len = 0;
        expected = (run_len == FilterLen);
        #1;
        check(tag, expected);
        if (pulse_out === 1'b1) begin
            pulses_seen++;
            gap = cyc - last_pulse_cyc;
            last_pulse_cyc = cyc;
        end
    endtask

    task automatic steps(input logic v, input int n, input string tag);
        for (int i = 0; i < n; i++) step(v, tag);
    endtask

    // Assert reset between edges; pulse_out must clear without waiting for a clock.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check(tag, 1'b0);
        run_len = 0;
        @(posedge clk);
        cyc++;
        #1;
        check(tag, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] pat;
        int p0;

        rst_n    = 1'b0;
        noisy_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 1'b0);
        rst_n = 1'b1;

        // Single-cycle glitch.
        p0 = pulses_seen;
        step(1'b1, "glitch");
        steps(1'b0, 5, "glitch_low");
        check_int("glitch_count", pulses_seen - p0, 0);

        // Clean 4-cycle high.
        p0 = pulses_seen;
        steps(1'b1, 4, "clean");
        steps(1'b0, 3, "clean_low");
        check_int("clean_count", pulses_seen - p0, 1);

        // Glitch during build-up: 1,0,1,1,1,1,0,0,0.
        p0 = pulses_seen;
        step(1'b1, "buildup");
        step(1'b0, "buildup");
        steps(1'b1, 4, "buildup");
        steps(1'b0, 3, "buildup_low");
        check_int("buildup_count", pulses_seen - p0, 1);

        // Long hold keeps to one pulse.
        p0 = pulses_seen;
        steps(1'b1, 13, "long_hold");
        step(1'b0, "long_hold_low");
        check_int("long_hold_count", pulses_seen - p0, 1);

        // Back-to-back runs, 7 cycles apart.
        steps(1'b0, 2, "b2b_pre");
        p0 = pulses_seen;
        for (int r = 0; r < 2; r++) begin
            steps(1'b1, 4, "b2b");
            steps(1'b0, 3, "b2b_low");
        end
        check_int("b2b_count", pulses_seen - p0, 2);
        check_int("b2b_gap", gap, 7);

        // Two 3-high runs split by one low: minimum separation FILTER_LEN+1.
        p0 = pulses_seen;
        steps(1'b1, 3, "min_sep");
        step(1'b0, "min_sep");
        steps(1'b1, 3, "min_sep");
        step(1'b0, "min_sep_low");
        check_int("min_sep_count", pulses_seen - p0, 2);
        check_int("min_sep_gap", gap, FilterLen + 1);

        // Noise 1,1,0,1,1,0,1,0 never qualifies.
        p0 = pulses_seen;
        pat = 8'b1101_1010;
        for (int i = 7; i >= 0; i--) step(pat[i], "noise");
        check_int("noise_count", pulses_seen - p0, 0);

        // Reset after two highs discards the partial run.
        p0 = pulses_seen;
        steps(1'b1, 2, "rst_mid");
        async_reset("rst_mid_async");
        steps(1'b1, 2, "rst_fresh");
        check_int("rst_partial_count", pulses_seen - p0, 0);
        step(1'b1, "rst_fresh_third");
        check_int("rst_fresh_count", pulses_seen - p0, 1);
        steps(1'b0, 2, "rst_fresh_low");

        // Reset while the pulse is high must clear it at once.
        steps(1'b1, 3, "rst_on_pulse");
        async_reset("rst_on_pulse_async");
        step(1'b1, "rst_on_pulse_after");
        step(1'b0, "rst_on_pulse_after");

        // Randomized runs with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                async_reset("rand_rst");
            end else begin
                // Bias towards high so runs of length >= FILTER_LEN occur often.
                step(logic'($urandom_range(0, 99) < 70), "random");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
